// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multi-cycle CPU sequencer with illegal-opcode flag and retired-instruction counter
module ctrl_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pause,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  output logic [3:0]       current_state,
  output logic             illegal_op,
  output logic             inst_retire,
  output logic [CNT_W-1:0] inst_count
);
  localparam logic [3:0] FETCH     = 4'd0;
  localparam logic [3:0] DECODE    = 4'd1;
  localparam logic [3:0] MEM_ADDR  = 4'd2;
  localparam logic [3:0] MEM_RD    = 4'd3;
  localparam logic [3:0] LD_WB     = 4'd4;
  localparam logic [3:0] MEM_WR    = 4'd5;
  localparam logic [3:0] R_EXE     = 4'd6;
  localparam logic [3:0] R_WB      = 4'd7;
  localparam logic [3:0] BRANCH    = 4'd8;
  localparam logic [3:0] JUMP      = 4'd9;
  localparam logic [3:0] I_WB      = 4'd10;
  localparam logic [3:0] SHIFT_EXE = 4'd11;
  localparam logic [3:0] I_EXE     = 4'd12;
  logic [3:0] next_state;
  logic [3:0] dec_state;
  logic       dec_bad;
  logic       retire_nxt;
  logic       illegal_nxt;
  // classify the instruction held in the IR into its first execution state
  always_comb begin
    dec_state = FETCH;
    dec_bad   = 1'b0;
    case (opcode)
      6'b000000:
        case (funct)
          6'b000000, 6'b000010, 6'b000011: dec_state = SHIFT_EXE;
          6'b100000, 6'b100010, 6'b100100, 6'b100101,
          6'b100110, 6'b100111, 6'b101010: dec_state = R_EXE;
          default: dec_bad = 1'b1;
        endcase
      6'b100011, 6'b101011: dec_state = MEM_ADDR;
      6'b000100, 6'b000101: dec_state = BRANCH;
      6'b000010: dec_state = JUMP;
      6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010: dec_state = I_EXE;
      default: dec_bad = 1'b1;
    endcase
  end
  // next-state selection; terminal, illegal and unused codes all fall back to FETCH
  always_comb begin
    next_state = FETCH;
    case (current_state)
      FETCH:            next_state = DECODE;
      DECODE:           next_state = dec_state;
      MEM_ADDR:         next_state = (opcode == 6'b100011) ? MEM_RD : MEM_WR;
      MEM_RD:           next_state = LD_WB;
      R_EXE, SHIFT_EXE: next_state = R_WB;
      I_EXE:            next_state = I_WB;
      default:          next_state = FETCH;
    endcase
  end
  // pulse requests for the coming edge; a paused edge requests nothing
  always_comb begin
    retire_nxt  = !pause && (current_state inside {LD_WB, MEM_WR, R_WB, BRANCH, JUMP, I_WB});
    illegal_nxt = !pause && (current_state == DECODE) && dec_bad;
  end
  // state, counter and registered pulses; pause freezes state and counter only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      current_state <= FETCH;
      illegal_op    <= 1'b0;
      inst_retire   <= 1'b0;
      inst_count    <= '0;
    end else begin
      if (!pause) current_state <= next_state;
      if (retire_nxt) inst_count <= inst_count + CNT_W'(1);
      illegal_op  <= illegal_nxt;
      inst_retire <= retire_nxt;
    end
  end
endmodule

// File: tb/tb_ctrl_fsm.sv
// tb_ctrl_fsm: randomized scoreboard bench for the CPU sequencer
module tb_ctrl_fsm;
  localparam int CW = 4;
  typedef struct {
    bit          ill;
    logic [CW-1:0] cnt;
    int          cyc;
  } ev_t;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pause = 1'b0;
  logic [5:0]    opcode = '0;
  logic [5:0]    funct = '0;
  logic [3:0]    current_state;
  logic          illegal_op;
  logic          inst_retire;
  logic [CW-1:0] inst_count;
  int            n_chk = 0;
  int            n_fail = 0;
  int            cyc = 0;
  logic [CW-1:0] cnt = '0;
  ev_t           sb[$];
  logic [5:0]    ops [0:10] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010,
                                6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010};
  logic [5:0]    fns [0:9]  = '{6'b000000, 6'b000010, 6'b000011, 6'b100000, 6'b100010,
                                6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101010};

  ctrl_fsm #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .pause(pause), .opcode(opcode), .funct(funct),
    .current_state(current_state), .illegal_op(illegal_op),
    .inst_retire(inst_retire), .inst_count(inst_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor: every pulse must match the oldest expected event
  always @(negedge clk) begin
    if (!rst && (inst_retire || illegal_op)) begin
      if (sb.size() == 0) chk("spurious_pulse", {illegal_op, inst_retire}, 2'b00);
      else begin
        ev_t e;
        e = sb.pop_front();
        chk("pulse_kind", {illegal_op, inst_retire}, e.ill ? 2'b10 : 2'b01);
        chk("pulse_count", inst_count, e.cnt);
        chk("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  // drive one instruction from FETCH; expected path comes from the instruction class
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int pprob,
                           input logic [15:0] hmask, input int rst_at);
    int path[$];
    bit ill = 0;
    int i = 0;
    int held = 0;
    path = '{0, 1};
    case (op)
      6'b000000:
        if (fn inside {6'b000000, 6'b000010, 6'b000011}) path = '{0, 1, 11, 7};
        else if (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101010})
          path = '{0, 1, 6, 7};
        else ill = 1;
      6'b100011: path = '{0, 1, 2, 3, 4};
      6'b101011: path = '{0, 1, 2, 5};
      6'b000100, 6'b000101: path = '{0, 1, 8};
      6'b000010: path = '{0, 1, 9};
      6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010: path = '{0, 1, 12, 10};
      default: ill = 1;
    endcase
    while (i < path.size()) begin
      chk("state", current_state, path[i]);
      chk("count", inst_count, cnt);
      if (rst_at == path[i]) begin
        #2 rst = 1'b1;
        #1;
        chk("async_rst_state", current_state, 0);
        chk("async_rst_count", inst_count, 0);
        chk("async_rst_pulse", {illegal_op, inst_retire}, 0);
        cnt = '0;
        pause = 1'b0;
        @(negedge clk);
        chk("rst_hold_state", current_state, 0);
        rst = 1'b0;
        return;
      end
      if (hmask[path[i]] && held < 3) begin
        pause = 1'b1;
        held++;
      end else pause = ($urandom_range(99) < pprob);
      opcode = (path[i] inside {1, 2}) ? op : 6'($urandom);
      funct  = (path[i] inside {1, 2}) ? fn : 6'($urandom);
      if (!pause) begin
        if (i == path.size() - 1) begin
          if (!ill) cnt = cnt + 1'b1;
          sb.push_back('{ill, cnt, cyc + 1});
        end
        i++;
        held = 0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #1;
    chk("rst_state", current_state, 0);
    chk("rst_pulses", {illegal_op, inst_retire}, 0);
    chk("rst_count", inst_count, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_instr(6'b100011, 6'h00, 0, 16'h0, -1);
    chk("t1_count", inst_count, 1);
    run_instr(6'b101011, 6'h00, 0, 16'h0, -1);
    run_instr(6'b000100, 6'h00, 0, 16'h0, -1);
    run_instr(6'b000010, 6'h00, 0, 16'h0, -1);
    run_instr(6'b001000, 6'h00, 0, 16'h0, -1);
    run_instr(6'b000000, 6'b100000, 0, 16'h0, -1);
    run_instr(6'b000000, 6'b000000, 0, 16'h0, -1);
    chk("t2_count", inst_count, 7);
    run_instr(6'b111111, 6'h00, 0, 16'h0, -1);
    run_instr(6'b000000, 6'b001000, 0, 16'h0, -1);
    chk("t3_count", inst_count, 7);
    run_instr(6'b100011, 6'h00, 0, 16'h0018, -1);
    chk("t4_count", inst_count, 8);
    run_instr(6'b101011, 6'h00, 0, 16'h0, 5);
    chk("t5_count", inst_count, 0);
    for (int k = 0; k < 80; k++) begin
      logic [5:0] op, fn;
      int sel;
      sel = $urandom_range(13);
      op = (sel < 11) ? ops[sel] : 6'($urandom);
      fn = ($urandom_range(3) != 0) ? fns[$urandom_range(9)] : 6'($urandom);
      run_instr(op, fn, 25, ($urandom_range(3) == 0) ? 16'($urandom) : 16'h0, -1);
    end
    pause = 1'b0;
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end, expected finish");
    $fatal(1, "timeout");
  end
endmodule
